// File: rtl/mmio_fabric_if.sv
// CPU-side load/store port plus the per-slave strobe/data/ready bundle of the MMIO fabric.
//   slave modport  : seen by the fabric (CPU request and slave responses in, strobes and result out)
//   master modport : seen by the surrounding CPU/slave environment
interface mmio_fabric_if #(
    parameter int unsigned NSLAVE = 4,
    parameter int unsigned DW     = 32
);
    logic                 req;
    logic                 memwrite;
    logic [31:0]          dataadr;
    logic [DW-1:0]        writedata;
    logic [DW-1:0]        readdata;
    logic                 stall;
    logic [NSLAVE-1:0]    s_we;
    logic [NSLAVE-1:0]    s_re;
    logic [1:0]           s_addr;
    logic [DW-1:0]        s_wdata;
    logic [NSLAVE*DW-1:0] s_rdata;
    logic [NSLAVE-1:0]    s_ready;
    logic                 err_clr;
    logic                 err;
    logic [31:0]          err_addr;

    modport slave (
        input  req, memwrite, dataadr, writedata, s_rdata, s_ready, err_clr,
        output readdata, stall, s_we, s_re, s_addr, s_wdata, err, err_addr
    );

    modport master (
        output req, memwrite, dataadr, writedata, s_rdata, s_ready, err_clr,
        input  readdata, stall, s_we, s_re, s_addr, s_wdata, err, err_addr
    );
endinterface

// File: rtl/mmio_fabric.sv
// Single-outstanding MMIO fabric: decodes a CPU load/store onto one of NSLAVE
// memory-mapped channels, waits for that slave's ready with a timeout, and
// reports unmapped or timed-out accesses through a sticky error flag.
//   Clk, reset : clock and synchronous active-high reset
//   bus        : mmio_fabric_if.slave (CPU request/stall/readdata, slave strobes/data/ready, err)
module mmio_fabric #(
    parameter int unsigned   NSLAVE   = 4,
    parameter int unsigned   DW       = 32,
    parameter int unsigned   SEL_LSB  = 8,
    parameter int unsigned   SEL_BITS = 4,
    parameter int unsigned   TIMEOUT  = 16,
    parameter logic [DW-1:0] ERR_DATA = DW'(32'hFFFF_FFFF)
) (
    input logic          Clk,
    input logic          reset,
    mmio_fabric_if.slave bus
);
    localparam int unsigned IW  = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
    localparam int unsigned CW  = 8;
    localparam int unsigned SW1 = SEL_BITS + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                we_q, we_d;
    logic [31:0]         adr_q, adr_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [NSLAVE-1:0]   s_we_q, s_we_d;
    logic [NSLAVE-1:0]   s_re_q, s_re_d;
    logic [1:0]          s_addr_q, s_addr_d;
    logic [DW-1:0]       s_wdata_q, s_wdata_d;
    logic                err_q, err_d;
    logic [31:0]         err_addr_q, err_addr_d;
    logic                err_set;

    logic [SEL_BITS-1:0] sel_idx;
    logic                mapped;
    logic                ready_sel;
    logic [DW-1:0]       rdata_sel;
    logic                timeout_hit;

    assign sel_idx     = bus.dataadr[SEL_LSB +: SEL_BITS];
    assign mapped      = {1'b0, sel_idx} < SW1'(NSLAVE);
    assign timeout_hit = (count_q == CW'(TIMEOUT - 1));

    // Pick the ready/read data of the latched slave only; other readies are ignored.
    always_comb begin
        ready_sel = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < int'(NSLAVE); i++) begin
            if (IW'(i) == idx_q) begin
                ready_sel = bus.s_ready[i];
                rdata_sel = bus.s_rdata[i*DW +: DW];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            rdata_q    <= '0;
            s_we_q     <= '0;
            s_re_q     <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            rdata_q    <= rdata_d;
            s_we_q     <= s_we_d;
            s_re_q     <= s_re_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req) state_d = mapped ? ACCESS : RESP;
            ACCESS:  if (ready_sel || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and transaction context.
    always_comb begin
        count_d    = count_q;
        idx_d      = idx_q;
        we_d       = we_q;
        adr_d      = adr_q;
        rdata_d    = rdata_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        err_addr_d = err_addr_q;
        err_set    = 1'b0;
        s_we_d     = '0;
        s_re_d     = '0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (mapped) begin
                        idx_d     = IW'(sel_idx);
                        we_d      = bus.memwrite;
                        adr_d     = bus.dataadr;
                        s_addr_d  = bus.dataadr[3:2];
                        s_wdata_d = bus.writedata;
                        count_d   = '0;
                    end else begin
                        rdata_d    = ERR_DATA;
                        err_set    = 1'b1;
                        err_addr_d = bus.dataadr;
                    end
                end
            end
            ACCESS: begin
                // Ready on the final allowed cycle still completes normally.
                if (ready_sel) begin
                    if (!we_q) rdata_d = rdata_sel;
                end else if (timeout_hit) begin
                    rdata_d    = ERR_DATA;
                    err_set    = 1'b1;
                    err_addr_d = adr_q;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: ;
        endcase

        // Strobes are registered so they are high for every cycle spent in ACCESS.
        if (state_d == ACCESS) begin
            for (int i = 0; i < int'(NSLAVE); i++) begin
                if (IW'(i) == idx_d) begin
                    s_we_d[i] = we_d;
                    s_re_d[i] = !we_d;
                end
            end
        end

        // A new error outranks a simultaneous clear.
        if (err_set)          err_d = 1'b1;
        else if (bus.err_clr) err_d = 1'b0;
        else                  err_d = err_q;
    end

    assign bus.stall    = bus.req && (state_q != RESP);
    assign bus.readdata = rdata_q;
    assign bus.s_we     = s_we_q;
    assign bus.s_re     = s_re_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.err      = err_q;
    assign bus.err_addr = err_addr_q;
endmodule
